cpu_amo_store_resp_noc: RTL and testbench
=========================================

Name: cpu_amo_store_resp_noc

Overview:
Response-side companion to the CPU-to-L2 AMO-store request NoC. It takes AMO-store completion responses from each L2 bank and routes each one back to the originating CPU port using the resp_tid.cpu_noc_id tag that the request NoC stamped in. Each CPU port has a round-robin arbiter over the L2 ports and an output FIFO. Each L2 port has an input FIFO.

Parameters:
BUF_IN_DEPTH, 2, per-L2-port input FIFO depth (must be at least 1)
BUF_OUT_DEPTH, 2, per-CPU-port output FIFO depth (must be at least 1)
CPU_PORT_CNT, 8, number of CPU response ports (power of 2)
L2_PORT_CNT, 8, number of L2 bank response ports

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
l2_amo_store_resp_valid  input  1 [L2_PORT_CNT]  L2 response valid
l2_amo_store_resp_ready  output  1 [L2_PORT_CNT]  L2 response ready
l2_amo_store_resp  input  cpu_cache_if_resp_t [L2_PORT_CNT]  L2 response payload
cpu_amo_store_noc_resp_valid  output  1 [CPU_PORT_CNT]  response valid to CPU
cpu_amo_store_noc_resp_ready  input  1 [CPU_PORT_CNT]  CPU ready
cpu_amo_store_noc_resp  output  cpu_cache_if_resp_t [CPU_PORT_CNT]  response to CPU
err_bad_id  output  1  sticky flag: a response carried cpu_noc_id >= CPU_PORT_CNT

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high. While rst is asserted:
  - all FIFOs are empty.
  - all valid outputs are 0.
  - l2_amo_store_resp_ready is 0.
  - all RR pointers are 0.
  - err_bad_id is 0.
- Reset mid-operation discards in-flight responses; no partial state survives.
- Input FIFO per L2 port j:
  - push when valid[j] and ready[j]; ready[j] = !full.
  - The head is registered: a push in cycle N becomes visible at the head in cycle N+1.
- Target decode: tgt[j] = head[j].resp_tid.cpu_noc_id[$clog2(CPU_PORT_CNT)-1:0].
  - If the full cpu_noc_id value is >= CPU_PORT_CNT, the head is popped without forwarding and err_bad_id sets.
  - err_bad_id stays set until reset.
- Per CPU port i, round-robin arbiter:
  - request vector req_i[j] = head valid[j] and tgt[j]==i.
  - grant when req_i is nonzero and out_fifo[i] is not full. Pushing into an output FIFO with a simultaneous pop in the same cycle is allowed even when it is full.
  - priority starts at ptr_i. After a grant to port g, ptr_i = (g+1) mod L2_PORT_CNT. ptr_i is unchanged when there is no grant.
  - at most one grant per CPU port per cycle.
- An input head is popped in the same cycle its target arbiter grants it. Each head has exactly one target, so no input is double-granted.
- Output FIFO per CPU port i:
  - cpu_amo_store_noc_resp_valid[i] = !empty; the payload is the FIFO head.
  - pop when valid and ready.
  - payload is forwarded unmodified.
- Latency: the minimum from L2 handshake to CPU valid is 2 cycles (input register plus output register).
- Throughput: 1 response per CPU port per cycle. Different CPU ports drain concurrently.
- Ordering: responses from the same L2 port to the same CPU stay in order. There is no ordering guarantee across L2 ports.
- Head-of-line blocking: a blocked CPU port stalls only the L2 input heads that target it.
- A full output FIFO with ready=0 stalls its arbiter; the other ports are unaffected.
- Pointer wrap: a grant to L2_PORT_CNT-1 sets ptr to 0.

Decomposition:
- cpu_cache_if_resp_t (with resp_tid.cpu_noc_id) lives in pygmy_intf_typedef.
- Port counts and the ID width constant live in pygmy_cfg.
- FIFOs reuse ours_vld_rdy_buf.
- One new sub-module: amo_resp_rr_arb. It is an N-input round-robin arbiter with a registered pointer, a grant-enable input and a one-hot grant output. It is instantiated once per CPU port.

Test Plan:
- Single response: L2 port 3 sends cpu_noc_id=5, CPU 5 ready=1 -> cpu_amo_store_noc_resp_valid[5]=1 exactly 2 cycles after the handshake, payload bit-identical, all other CPU valids 0.
- Contention: L2 ports 0, 2 and 7 each send one response to CPU 1 in the same cycle, CPU 1 ready=1, ptr=0 -> CPU 1 receives in order 0, 2, 7 on consecutive cycles; pointer ends at 0 (wrapped).
- Backpressure: CPU 4 ready=0 while L2 port 0 streams 5 responses to CPU 4 -> output FIFO holds 2, input FIFO holds 2, l2_amo_store_resp_ready[0]=0 after 4 accepts; releasing ready drains all 5 in order.
- Independence: CPU 4 is blocked as above while L2 port 1 streams to CPU 6 -> CPU 6 receives one response per cycle, unaffected.
- Bad ID: with CPU_PORT_CNT=8, a response arrives with cpu_noc_id=9 -> it is consumed, no CPU valid is raised, err_bad_id=1 from the next cycle and stays 1.
- Reset mid-flight: assert rst with 3 responses queued -> valids drop and l2 readies are 0 while rst is high. After deassert, all FIFOs are empty, err_bad_id=0, ptr=0, and new traffic routes normally.

Source files
------------

// File: rtl/cpu_amo_store_resp_noc_pkg.sv
// Shared types for the AMO-store response NoC.
// Response payload carries the CPU NoC id stamped by the request side.
package cpu_amo_store_resp_noc_pkg;

  localparam int CPU_NOC_ID_W = 4;
  localparam int TID_W        = 8;
  localparam int DATA_W       = 32;

  typedef struct packed {
    logic [CPU_NOC_ID_W-1:0] cpu_noc_id;
    logic [TID_W-1:0]        tid;
  } cpu_cache_if_tid_t;

  typedef struct packed {
    cpu_cache_if_tid_t   resp_tid;
    logic [DATA_W-1:0]   data;
    logic                err;
  } cpu_cache_if_resp_t;

  function automatic logic id_in_range(
    input logic [CPU_NOC_ID_W-1:0] id,
    input int                      cnt
  );
    return int'(id) < cnt;
  endfunction

endpackage

// File: rtl/amo_resp_rr_arb.sv
// N-input round-robin arbiter, one-hot grant.
// Pointer moves just past the winner only on an enabled grant.
module amo_resp_rr_arb #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic          any;

  always_comb begin
    gnt = '0;
    win = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any = 1'b1;
        win = PW'((int'(ptr) + k) % N);
      end
    end
    if (en && any) gnt[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && any) begin
      ptr <= (int'(win) == N - 1) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/ours_vld_rdy_buf.sv
// Valid/ready FIFO with registered head.
// FULL_PASS lets a full buffer accept a push in a popping cycle.
module ours_vld_rdy_buf #(
  parameter type T         = logic,
  parameter int  DEPTH     = 2,
  parameter bit  FULL_PASS = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  cnt;
  logic           full;
  logic           push;
  logic           pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign full      = (cnt == CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign in_ready  = !full || (FULL_PASS && pop);
  assign push      = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/cpu_amo_store_resp_noc.sv
// Routes L2 AMO-store responses back to CPU ports by cpu_noc_id.
// Per-L2 input FIFO, per-CPU round-robin arbiter and output FIFO.
module cpu_amo_store_resp_noc
  import cpu_amo_store_resp_noc_pkg::*;
#(
  parameter int BUF_IN_DEPTH  = 2,
  parameter int BUF_OUT_DEPTH = 2,
  parameter int CPU_PORT_CNT  = 8,
  parameter int L2_PORT_CNT   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [L2_PORT_CNT-1:0]  l2_amo_store_resp_valid,
  output logic [L2_PORT_CNT-1:0]  l2_amo_store_resp_ready,
  input  cpu_cache_if_resp_t      l2_amo_store_resp
                                    [L2_PORT_CNT],
  output logic [CPU_PORT_CNT-1:0] cpu_amo_store_noc_resp_valid,
  input  logic [CPU_PORT_CNT-1:0] cpu_amo_store_noc_resp_ready,
  output cpu_cache_if_resp_t      cpu_amo_store_noc_resp
                                    [CPU_PORT_CNT],
  output logic                    err_bad_id
);

  localparam int TW = $clog2(CPU_PORT_CNT);

  logic [L2_PORT_CNT-1:0]  fifo_rdy;
  logic [L2_PORT_CNT-1:0]  in_vld;
  logic [L2_PORT_CNT-1:0]  in_pop;
  logic [L2_PORT_CNT-1:0]  bad;
  cpu_cache_if_resp_t      in_head [L2_PORT_CNT];
  logic [TW-1:0]           tgt [L2_PORT_CNT];

  logic [L2_PORT_CNT-1:0]  req [CPU_PORT_CNT];
  logic [L2_PORT_CNT-1:0]  gnt [CPU_PORT_CNT];
  logic [CPU_PORT_CNT-1:0] out_push;
  logic [CPU_PORT_CNT-1:0] out_rdy;
  cpu_cache_if_resp_t      out_din [CPU_PORT_CNT];

  // Ready is held low while reset is asserted.
  assign l2_amo_store_resp_ready = fifo_rdy & {L2_PORT_CNT{~rst}};

  for (genvar j = 0; j < L2_PORT_CNT; j++) begin : g_in
    ours_vld_rdy_buf #(
      .T         (cpu_cache_if_resp_t),
      .DEPTH     (BUF_IN_DEPTH),
      .FULL_PASS (1'b0)
    ) u_in_buf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (l2_amo_store_resp_valid[j]),
      .in_ready  (fifo_rdy[j]),
      .in_data   (l2_amo_store_resp[j]),
      .out_valid (in_vld[j]),
      .out_ready (in_pop[j]),
      .out_data  (in_head[j])
    );

    assign tgt[j] =
      in_head[j].resp_tid.cpu_noc_id[TW-1:0];
    assign bad[j] = in_vld[j] && !id_in_range(
      in_head[j].resp_tid.cpu_noc_id, CPU_PORT_CNT);
  end

  always_comb begin
    for (int i = 0; i < CPU_PORT_CNT; i++) begin
      for (int j = 0; j < L2_PORT_CNT; j++) begin
        req[i][j] = in_vld[j] && !bad[j] &&
                    (int'(tgt[j]) == i);
      end
    end
  end

  for (genvar i = 0; i < CPU_PORT_CNT; i++) begin : g_out
    amo_resp_rr_arb #(
      .N (L2_PORT_CNT)
    ) u_arb (
      .clk (clk),
      .rst (rst),
      .req (req[i]),
      .en  (out_rdy[i]),
      .gnt (gnt[i])
    );

    ours_vld_rdy_buf #(
      .T         (cpu_cache_if_resp_t),
      .DEPTH     (BUF_OUT_DEPTH),
      .FULL_PASS (1'b1)
    ) u_out_buf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (out_push[i]),
      .in_ready  (out_rdy[i]),
      .in_data   (out_din[i]),
      .out_valid (cpu_amo_store_noc_resp_valid[i]),
      .out_ready (cpu_amo_store_noc_resp_ready[i]),
      .out_data  (cpu_amo_store_noc_resp[i])
    );
  end

  // Bad-id heads drop; good heads pop when their arbiter grants.
  always_comb begin
    in_pop = bad;
    for (int i = 0; i < CPU_PORT_CNT; i++) begin
      out_push[i] = |gnt[i];
      out_din[i]  = '0;
      for (int j = 0; j < L2_PORT_CNT; j++) begin
        if (gnt[i][j]) begin
          out_din[i] = in_head[j];
          in_pop[j]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_bad_id <= 1'b0;
    end else if (|bad) begin
      err_bad_id <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_amo_store_resp_noc.sv
// Bench for cpu_amo_store_resp_noc: directed scenarios plus
// random traffic against a per-CPU expected-response model.
module tb_cpu_amo_store_resp_noc;
  import cpu_amo_store_resp_noc_pkg::*;

  localparam int NC = 8;
  localparam int NL = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NL-1:0]       l2_valid;
  logic [NL-1:0]       l2_ready;
  cpu_cache_if_resp_t  l2_resp [NL];
  logic [NC-1:0]       cpu_valid;
  logic [NC-1:0]       cpu_ready;
  cpu_cache_if_resp_t  cpu_resp [NC];
  logic                err_bad_id;

  int checks = 0;
  int errors = 0;
  int seq [NL];

  cpu_cache_if_resp_t exp_q [NC][$];

  always #5 clk = ~clk;

  cpu_amo_store_resp_noc #(
    .BUF_IN_DEPTH  (2),
    .BUF_OUT_DEPTH (2),
    .CPU_PORT_CNT  (NC),
    .L2_PORT_CNT   (NL)
  ) dut (
    .clk                          (clk),
    .rst                          (rst),
    .l2_amo_store_resp_valid      (l2_valid),
    .l2_amo_store_resp_ready      (l2_ready),
    .l2_amo_store_resp            (l2_resp),
    .cpu_amo_store_noc_resp_valid (cpu_valid),
    .cpu_amo_store_noc_resp_ready (cpu_ready),
    .cpu_amo_store_noc_resp       (cpu_resp),
    .err_bad_id                   (err_bad_id)
  );

  function automatic cpu_cache_if_resp_t mk(
    input int src, input int id
  );
    cpu_cache_if_resp_t r;
    r.resp_tid.cpu_noc_id = 4'(id);
    r.resp_tid.tid = {3'(src), 5'(seq[src])};
    r.data = $urandom;
    r.err  = 1'($urandom % 2);
    seq[src] = seq[src] + 1;
    return r;
  endfunction

  // Record this cycle's handshakes, then advance to next negedge.
  task automatic tick();
    cpu_cache_if_resp_t got;
    int k;
    #1;
    if (!rst) begin
      for (int j = 0; j < NL; j++) begin
        if (l2_valid[j] && l2_ready[j] &&
            l2_resp[j].resp_tid.cpu_noc_id < 4'(NC))
          exp_q[l2_resp[j].resp_tid.cpu_noc_id[2:0]]
            .push_back(l2_resp[j]);
      end
      for (int i = 0; i < NC; i++) begin
        if (cpu_valid[i] && cpu_ready[i]) begin
          got = cpu_resp[i];
          k = -1;
          for (int n = 0; n < exp_q[i].size(); n++)
            if (k < 0 && exp_q[i][n].resp_tid.tid[7:5] ==
                got.resp_tid.tid[7:5])
              k = n;
          checks++;
          if (k < 0) begin
            errors++;
            $display("FAIL model_cpu%0d got %h expected none",
                     i, got);
          end else begin
            if (exp_q[i][k] !== got) begin
              errors++;
              $display("FAIL model_cpu%0d got %h expected %h",
                       i, got, exp_q[i][k]);
            end
            exp_q[i].delete(k);
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    l2_valid = '0;
    cpu_ready = '0;
    for (int j = 0; j < NL; j++) l2_resp[j] = '0;
    @(negedge clk);
    #1;
    checks++;
    if (cpu_valid !== '0 || l2_ready !== '0 ||
        err_bad_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got v=%h r=%h e=%b expected 0",
               cpu_valid, l2_ready, err_bad_id);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    #1;
    checks++;
    if (l2_ready !== '1 || cpu_valid !== '0) begin
      errors++;
      $display("FAIL reset_release got r=%h v=%h expected ff 00",
               l2_ready, cpu_valid);
    end
  endtask

  task automatic test_single();
    cpu_cache_if_resp_t p;
    cpu_ready = '1;
    p = mk(3, 5);
    l2_valid[3] = 1'b1;
    l2_resp[3] = p;
    #1;
    checks++;
    if (l2_ready[3] !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got %b expected 1", l2_ready[3]);
    end
    tick();
    l2_valid[3] = 1'b0;
    #1;
    checks++;
    if (cpu_valid !== '0) begin
      errors++;
      $display("FAIL single_early got %h expected 00", cpu_valid);
    end
    tick();
    #1;
    checks++;
    if (cpu_valid !== 8'h20 || cpu_resp[5] !== p) begin
      errors++;
      $display("FAIL single_lat2 got %h/%h expected 20/%h",
               cpu_valid, cpu_resp[5], p);
    end
    tick();
  endtask

  task automatic test_contention();
    cpu_cache_if_resp_t p [3];
    int src [3] = '{0, 2, 7};
    cpu_ready = '1;
    for (int k = 0; k < 3; k++) begin
      p[k] = mk(src[k], 1);
      l2_valid[src[k]] = 1'b1;
      l2_resp[src[k]] = p[k];
    end
    tick();
    l2_valid = '0;
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (!cpu_valid[1] || cpu_resp[1] !== p[k]) begin
        errors++;
        $display("FAIL contention_%0d got %b/%h expected 1/%h",
                 k, cpu_valid[1], cpu_resp[1], p[k]);
      end
      tick();
    end
    // Pointer wrapped to 0: port 0 must beat port 1.
    p[0] = mk(1, 1);
    p[1] = mk(0, 1);
    l2_valid[1] = 1'b1;
    l2_resp[1] = p[0];
    l2_valid[0] = 1'b1;
    l2_resp[0] = p[1];
    tick();
    l2_valid = '0;
    tick();
    #1;
    checks++;
    if (cpu_resp[1] !== p[1]) begin
      errors++;
      $display("FAIL ptr_wrap_first got %h expected %h",
               cpu_resp[1], p[1]);
    end
    tick();
    #1;
    checks++;
    if (cpu_resp[1] !== p[0]) begin
      errors++;
      $display("FAIL ptr_wrap_second got %h expected %h",
               cpu_resp[1], p[0]);
    end
    tick();
  endtask

  task automatic test_back_pressure();
    cpu_cache_if_resp_t bp [5];
    cpu_cache_if_resp_t got [5];
    int acc = 0;
    int c6 = 0;
    int n = 0;
    for (int k = 0; k < 5; k++) bp[k] = mk(0, 4);
    cpu_ready = '1;
    cpu_ready[4] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      l2_valid[0] = (acc < 5);
      l2_resp[0] = bp[acc < 5 ? acc : 4];
      l2_valid[1] = 1'b1;
      l2_resp[1] = mk(1, 6);
      #1;
      if (l2_valid[0] && l2_ready[0]) acc++;
      if (cpu_valid[6]) c6++;
      tick();
    end
    l2_valid[1] = 1'b0;
    #1;
    checks++;
    if (acc != 4 || l2_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_accepts got %0d/%b expected 4/0",
               acc, l2_ready[0]);
    end
    checks++;
    if (c6 != 6) begin
      errors++;
      $display("FAIL indep_cpu6 got %0d expected 6", c6);
    end
    cpu_ready[4] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      l2_valid[0] = (acc < 5);
      l2_resp[0] = bp[acc < 5 ? acc : 4];
      #1;
      if (l2_valid[0] && l2_ready[0]) acc++;
      if (cpu_valid[4] && n < 5) begin
        got[n] = cpu_resp[4];
        n++;
      end
      tick();
    end
    l2_valid[0] = 1'b0;
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL bp_drain_cnt got %0d expected 5", n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got[k] !== bp[k]) begin
        errors++;
        $display("FAIL bp_order_%0d got %h expected %h",
                 k, got[k], bp[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < NL; j++) begin
        l2_valid[j] = ($urandom % 3) != 0;
        l2_resp[j] = mk(j, int'($urandom % NC));
      end
      for (int i = 0; i < NC; i++)
        cpu_ready[i] = ($urandom % 4) != 0;
      tick();
    end
    l2_valid = '0;
    cpu_ready = '1;
    for (int c = 0; c < 30; c++) tick();
    for (int i = 0; i < NC; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL rand_drain_cpu%0d got %0d left expected 0",
                 i, exp_q[i].size());
      end
    end
    checks++;
    if (err_bad_id !== 1'b0) begin
      errors++;
      $display("FAIL rand_err got %b expected 0", err_bad_id);
    end
  endtask

  task automatic test_bad_id();
    cpu_ready = '1;
    l2_valid[2] = 1'b1;
    l2_resp[2] = mk(2, 9);
    #1;
    checks++;
    if (err_bad_id !== 1'b0) begin
      errors++;
      $display("FAIL bad_pre got %b expected 0", err_bad_id);
    end
    tick();
    l2_valid = '0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      checks++;
      if (cpu_valid !== '0) begin
        errors++;
        $display("FAIL bad_novalid got %h expected 00", cpu_valid);
      end
      if (k >= 2) begin
        checks++;
        if (err_bad_id !== 1'b1) begin
          errors++;
          $display("FAIL bad_sticky_%0d got %b expected 1",
                   k, err_bad_id);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    cpu_cache_if_resp_t r1;
    cpu_cache_if_resp_t r5;
    cpu_ready = '0;
    l2_valid[0] = 1'b1;
    l2_resp[0] = mk(0, 3);
    l2_valid[1] = 1'b1;
    l2_resp[1] = mk(1, 3);
    l2_valid[2] = 1'b1;
    l2_resp[2] = mk(2, 5);
    tick();
    l2_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (cpu_valid !== '0 || l2_ready !== '0 ||
        err_bad_id !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got v=%h r=%h e=%b expected 0",
               cpu_valid, l2_ready, err_bad_id);
    end
    for (int i = 0; i < NC; i++) exp_q[i].delete();
    tick();
    rst = 1'b0;
    tick();
    #1;
    checks++;
    if (cpu_valid !== '0 || l2_ready !== '1 ||
        err_bad_id !== 1'b0) begin
      errors++;
      $display("FAIL rst_after got v=%h r=%h e=%b expected 00/ff/0",
               cpu_valid, l2_ready, err_bad_id);
    end
    // Pointer back at 0: port 1 must beat port 5.
    cpu_ready = '1;
    r5 = mk(5, 3);
    r1 = mk(1, 3);
    l2_valid[5] = 1'b1;
    l2_resp[5] = r5;
    l2_valid[1] = 1'b1;
    l2_resp[1] = r1;
    tick();
    l2_valid = '0;
    tick();
    #1;
    checks++;
    if (cpu_valid !== 8'h08 || cpu_resp[3] !== r1) begin
      errors++;
      $display("FAIL rst_route_first got %h/%h expected 08/%h",
               cpu_valid, cpu_resp[3], r1);
    end
    tick();
    #1;
    checks++;
    if (cpu_resp[3] !== r5) begin
      errors++;
      $display("FAIL rst_route_second got %h expected %h",
               cpu_resp[3], r5);
    end
    tick();
    tick();
  endtask

  initial begin
    for (int j = 0; j < NL; j++) seq[j] = 0;
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_random();
    test_bad_id();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
